// File: rtl/sim_pkg.sv
// sim_pkg: shared scheduler state encoding, coordinate width default and index-width helper.
package sim_pkg;
  typedef enum logic [1:0] {IDLE, VERLET, CONSTRAINT, DONE} state_e;
  localparam int COORD_W_DEF = 32;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/sim_step_scheduler_if.sv
// sim_step_scheduler_if: link/iteration issue handshake between scheduler and constraint solver.
interface sim_step_scheduler_if #(parameter int LW = 1, parameter int IW = 1);
  logic          link_valid;
  logic          link_ready;
  logic [LW-1:0] link_idx;
  logic [IW-1:0] iter_idx;
  modport master(output link_valid, link_idx, iter_idx, input link_ready);
  modport slave(input link_valid, link_idx, iter_idx, output link_ready);
endinterface

// File: rtl/sched_link_counter.sv
// sched_link_counter: nested link/iteration counter with advance, wrap, clear and last flag.
module sched_link_counter
  import sim_pkg::*;
#(
  parameter int NUM_LINKS = 16,
  parameter int ITERS = 4,
  localparam int LW = idx_w(NUM_LINKS),
  localparam int IW = idx_w(ITERS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          adv,
  input  logic          clr,
  output logic [LW-1:0] link_idx,
  output logic [IW-1:0] iter_idx,
  output logic          last
);
  logic [LW-1:0] link_q, link_d;
  logic [IW-1:0] iter_q, iter_d;
  logic link_last, iter_last;
  always_comb begin
    link_last = link_q == LW'(NUM_LINKS - 1);
    iter_last = iter_q == IW'(ITERS - 1);
    link_d = clr ? '0 : adv ? (link_last ? '0 : link_q + LW'(1)) : link_q;
    iter_d = clr ? '0 : (adv && link_last) ? (iter_last ? '0 : iter_q + IW'(1)) : iter_q;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      link_q <= '0;
      iter_q <= '0;
    end else begin
      link_q <= link_d;
      iter_q <= iter_d;
    end
  assign link_idx = link_q;
  assign iter_idx = iter_q;
  assign last = link_last && iter_last;
endmodule

// File: rtl/sim_step_scheduler.sv
// sim_step_scheduler: per-frame Verlet + constraint-relaxation sequencer.
// SIM_PAUSE_EN adds a pause input that freezes the frame in place.
module sim_step_scheduler
  import sim_pkg::*;
#(
  parameter int NUM_LINKS = 16,
  parameter int ITERS = 4,
  parameter int VERLET_CYCLES = 2,
  parameter int COORD_W = COORD_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
`ifdef SIM_PAUSE_EN
  input  logic               pause,
`endif
  input  logic               frame_tick,
  input  logic [COORD_W-1:0] x_mouse_in,
  input  logic [COORD_W-1:0] y_mouse_in,
  output logic [COORD_W-1:0] x_mouse,
  output logic [COORD_W-1:0] y_mouse,
  output logic               verlet_state,
  output logic               fix_constraint_state,
  output logic               busy,
  output logic               frame_done,
  output logic               overrun,
  sim_step_scheduler_if.master lnk
);
  localparam int LW = idx_w(NUM_LINKS);
  localparam int IW = idx_w(ITERS);
  localparam int VW = idx_w(VERLET_CYCLES);
  state_e state_q, state_d;
  logic [VW-1:0] vcnt_q, vcnt_d;
  logic [COORD_W-1:0] xm_q, xm_d, ym_q, ym_d;
  logic verlet_q, verlet_d, fix_q, fix_d, valid_q, valid_d;
  logic busy_q, busy_d, done_q, done_d, over_q, over_d;
  logic pause_w, hs, last;
  logic [LW-1:0] link_idx;
  logic [IW-1:0] iter_idx;
`ifdef SIM_PAUSE_EN
  assign pause_w = pause;
`else
  assign pause_w = 1'b0;
`endif
  assign hs = valid_q && lnk.link_ready;
  sched_link_counter #(.NUM_LINKS(NUM_LINKS), .ITERS(ITERS)) u_cnt (
    .clk     (clk),
    .reset   (reset),
    .adv     (hs),
    .clr     (state_q == DONE),
    .link_idx(link_idx),
    .iter_idx(iter_idx),
    .last    (last)
  );
  // Verlet cycles are counted only while verlet_state is actually asserted.
  always_comb begin
    state_d = state_q;
    vcnt_d = vcnt_q;
    xm_d = xm_q;
    ym_d = ym_q;
    case (state_q)
      IDLE:
        if (frame_tick && !pause_w) begin
          state_d = VERLET;
          vcnt_d = '0;
          xm_d = x_mouse_in;
          ym_d = y_mouse_in;
        end
      VERLET:
        if (verlet_q) begin
          vcnt_d = vcnt_q + VW'(1);
          state_d = (vcnt_q == VW'(VERLET_CYCLES - 1)) ? CONSTRAINT : VERLET;
        end
      CONSTRAINT: state_d = (hs && last) ? DONE : CONSTRAINT;
      default: state_d = IDLE;
    endcase
    verlet_d = state_d == VERLET && !pause_w;
    fix_d = state_d == CONSTRAINT;
    valid_d = state_d == CONSTRAINT && (!pause_w || (valid_q && !lnk.link_ready));
    busy_d = state_d != IDLE;
    done_d = state_d == DONE;
    over_d = frame_tick && state_q != IDLE;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      vcnt_q <= '0;
      xm_q <= '0;
      ym_q <= '0;
      verlet_q <= 1'b0;
      fix_q <= 1'b0;
      valid_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      over_q <= 1'b0;
    end else begin
      state_q <= state_d;
      vcnt_q <= vcnt_d;
      xm_q <= xm_d;
      ym_q <= ym_d;
      verlet_q <= verlet_d;
      fix_q <= fix_d;
      valid_q <= valid_d;
      busy_q <= busy_d;
      done_q <= done_d;
      over_q <= over_d;
    end
  assign x_mouse = xm_q;
  assign y_mouse = ym_q;
  assign verlet_state = verlet_q;
  assign fix_constraint_state = fix_q;
  assign busy = busy_q;
  assign frame_done = done_q;
  assign overrun = over_q;
  assign lnk.link_valid = valid_q;
  assign lnk.link_idx = link_idx;
  assign lnk.iter_idx = iter_idx;
endmodule

// File: tb/tb_sim_step_scheduler.sv
// tb_sim_step_scheduler: directed frame sequences with cycle-exact expectations.
module tb_sim_step_scheduler;
  localparam int NL = 4;
  localparam int NI = 3;
  localparam int VC = 2;
  logic clk, reset, frame_tick;
  logic [31:0] x_in, y_in, x_mouse, y_mouse;
  logic verlet_state, fix_constraint_state, busy, frame_done, overrun;
  int checks = 0;
  int errors = 0;
  sim_step_scheduler_if #(.LW(2), .IW(2)) lnk ();
  sim_step_scheduler #(.NUM_LINKS(NL), .ITERS(NI), .VERLET_CYCLES(VC), .COORD_W(32)) dut (
    .clk                 (clk),
    .reset               (reset),
`ifdef SIM_PAUSE_EN
    .pause               (1'b0),
`endif
    .frame_tick          (frame_tick),
    .x_mouse_in          (x_in),
    .y_mouse_in          (y_in),
    .x_mouse             (x_mouse),
    .y_mouse             (y_mouse),
    .verlet_state        (verlet_state),
    .fix_constraint_state(fix_constraint_state),
    .busy                (busy),
    .frame_done          (frame_done),
    .overrun             (overrun),
    .lnk                 (lnk)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic check_idle(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_verlet"}, verlet_state, 0);
    check({tag, "_fix"}, fix_constraint_state, 0);
    check({tag, "_valid"}, lnk.link_valid, 0);
    check({tag, "_done"}, frame_done, 0);
    check({tag, "_link"}, lnk.link_idx, 0);
    check({tag, "_iter"}, lnk.iter_idx, 0);
  endtask
  // Tick sampled at edge 0; cycle c is the interval after edge c-1.
  task automatic run_frame(input int stall_len, input int tick2, input logic [31:0] mx, input logic [31:0] my);
    int l = 0, it = 0, stalled = 0, hs = 0, last;
    last = VC + NL * NI + 1 + stall_len;
    @(negedge clk);
    frame_tick = 1'b1;
    x_in = mx;
    y_in = my;
    lnk.link_ready = 1'b1;
    for (int c = 1; c <= last + 1; c++) begin
      @(negedge clk);
      frame_tick = (c == tick2);
      x_in = mx + 32'(c * 7);
      y_in = my ^ 32'(c);
      check("verlet", verlet_state, c <= VC);
      check("fix", fix_constraint_state, c > VC && c < last);
      check("valid", lnk.link_valid, c > VC && c < last);
      check("done", frame_done, c == last);
      check("busy", busy, c <= last);
      check("overrun", overrun, tick2 != 0 && c == tick2 + 1);
      check("x_mouse", x_mouse, mx);
      check("y_mouse", y_mouse, my);
      if (lnk.link_valid) begin
        check("link_idx", lnk.link_idx, l);
        check("iter_idx", lnk.iter_idx, it);
        if (l == 2 && it == 0 && stalled < stall_len) begin
          lnk.link_ready = 1'b0;
          stalled++;
        end else begin
          lnk.link_ready = 1'b1;
          hs++;
          l++;
          if (l == NL) begin
            l = 0;
            it++;
          end
        end
      end else lnk.link_ready = 1'b1;
    end
    frame_tick = 1'b0;
    check("handshakes", hs, NL * NI);
    check("iter_clr", lnk.iter_idx, 0);
  endtask
  initial begin
    reset = 1'b0;
    frame_tick = 1'b1;
    x_in = 32'd5;
    y_in = 32'd7;
    lnk.link_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_idle("rst");
      check("rst_x", x_mouse, 0);
      check("rst_y", y_mouse, 0);
      check("rst_over", overrun, 0);
    end
    frame_tick = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check_idle("post_rst");
    run_frame(0, 0, 32'd200, 32'd10);
    @(negedge clk);
    check("hold_x", x_mouse, 200);
    check("hold_y", y_mouse, 10);
    run_frame(3, 0, 32'd33, 32'd44);
    run_frame(0, 5, 32'd1, 32'd2);
    @(negedge clk);
    frame_tick = 1'b1;
    x_in = 32'd9;
    @(negedge clk);
    frame_tick = 1'b0;
    repeat (7) @(negedge clk);
    check("pre_abort_valid", lnk.link_valid, 1);
    check("pre_abort_iter", lnk.iter_idx, 1);
    check("pre_abort_link", lnk.link_idx, 1);
    reset = 1'b0;
    #1;
    check_idle("abort");
    check("abort_x", x_mouse, 0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("abort_no_done", frame_done, 0);
      check("abort_busy", busy, 0);
    end
    run_frame(0, 0, 32'd77, 32'd88);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
